// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - fetch/decode/execute/writeback sequencer for the 4-bit processor
module cpu_sequencer #(
    parameter int PC_W     = 4,
    parameter int PROG_LEN = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stop,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [3:0]      imem_data,
    output logic            alu_en,
    output logic            alu_op,
    output logic [1:0]      alu_imm,
    output logic            rf_sel,
    output logic            rf_we,
    output logic            busy,
    output logic            halted,
    output logic [PC_W-1:0] pc_o
);

    // One-hot state bit positions; strobes are taken straight from these flops.
    localparam int B_IDLE   = 0;
    localparam int B_FETCH  = 1;
    localparam int B_DECODE = 2;
    localparam int B_EXEC   = 3;
    localparam int B_WB     = 4;
    localparam int B_HALT   = 5;

    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_FETCH  = 6'b000010,
        S_DECODE = 6'b000100,
        S_EXEC   = 6'b001000,
        S_WB     = 6'b010000,
        S_HALT   = 6'b100000
    } state_t;

    // Last legal program address; wrap happens here rather than at PC_W overflow.
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_LEN - 1);
    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

    state_t          state;
    state_t          state_next;
    logic [PC_W-1:0] pc;
    logic [3:0]      instr;
    logic            stop_pend;
    logic            pc_at_last;
    logic            in_flight;

    assign pc_at_last = (pc == PC_LAST);
    assign in_flight  = state[B_FETCH] | state[B_DECODE] | state[B_EXEC] | state[B_WB];

    // State register; reset forces IDLE so every decoded output drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one instruction at a time, halt after WB of last or stopped instruction.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                state_next = S_EXEC;
            end
            S_EXEC: begin
                state_next = S_WB;
            end
            S_WB: begin
                if (pc_at_last || stop_pend || stop) begin
                    state_next = S_HALT;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_HALT: begin
                if (start) begin
                    state_next = S_FETCH;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Program counter: advances modulo PROG_LEN at WB, rewinds to 0 on a fresh start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (state[B_WB]) begin
            pc <= pc_at_last ? '0 : pc + PC_ONE;
        end else if ((state[B_IDLE] || state[B_HALT]) && start) begin
            pc <= '0;
        end
    end

    // Instruction latch: only the accepting FETCH edge may load imem_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= '0;
        end else if (state[B_FETCH] && imem_ack) begin
            instr <= imem_data;
        end
    end

    // Sticky stop request, armed only while an instruction is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_pend <= 1'b0;
        end else if (state[B_HALT]) begin
            stop_pend <= 1'b0;
        end else if (in_flight && stop) begin
            stop_pend <= 1'b1;
        end
    end

    assign imem_req  = state[B_FETCH];
    assign imem_addr = pc;
    assign alu_en    = state[B_EXEC];
    assign rf_we     = state[B_WB];
    assign busy      = in_flight;
    assign halted    = state[B_HALT];
    assign pc_o      = pc;

    assign rf_sel    = instr[3];
    assign alu_op    = instr[2];
    assign alu_imm   = instr[1:0];

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer
module tb_cpu_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       imem_req;
    logic [3:0] imem_addr;
    logic       imem_ack;
    logic [3:0] imem_data;
    logic       alu_en;
    logic       alu_op;
    logic [1:0] alu_imm;
    logic       rf_sel;
    logic       rf_we;
    logic       busy;
    logic       halted;
    logic [3:0] pc_o;

    cpu_sequencer #(.PC_W(4), .PROG_LEN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .alu_en    (alu_en),
        .alu_op    (alu_op),
        .alu_imm   (alu_imm),
        .rf_sel    (rf_sel),
        .rf_we     (rf_we),
        .busy      (busy),
        .halted    (halted),
        .pc_o      (pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int pc;
        int sel;
        int op;
        int imm;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] prog     [16];
    int         wait_cfg [16];
    logic       junk_on;

    int exp_sel [4] = '{1, 0, 0, 1};
    int exp_op  [4] = '{0, 1, 0, 1};
    int exp_imm [4] = '{3, 2, 1, 0};

    int busy_cnt = 0;
    int alu_cnt  = 0;
    int we_cnt   = 0;
    int req1_cnt = 0;
    int req3_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs_vec();
        return int'({imem_req, imem_addr, alu_en, alu_op, alu_imm, rf_sel, rf_we, busy, halted, pc_o});
    endfunction

    task automatic push_prog(input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.pc  = i;
            e.sel = exp_sel[i];
            e.op  = exp_op[i];
            e.imm = exp_imm[i];
            sb.push_back(e);
        end
    endtask

    // Instruction memory responder with per-address ack wait and optional junk acks.
    initial begin
        int wcnt;
        wcnt      = 0;
        imem_ack  = 1'b0;
        imem_data = 4'h0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (wcnt >= wait_cfg[imem_addr]) begin
                    imem_ack  = 1'b1;
                    imem_data = prog[imem_addr];
                end else begin
                    imem_ack  = 1'b0;
                    imem_data = 4'h0;
                    wcnt++;
                end
            end else begin
                wcnt      = 0;
                imem_ack  = junk_on;
                imem_data = junk_on ? 4'hF : 4'h0;
            end
        end
    end

    // Monitor: counts activity and compares each strobe against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (imem_req && imem_addr == 4'd1) req1_cnt++;
            if (imem_req && imem_addr == 4'd3) req3_cnt++;
            if (alu_en) begin
                alu_cnt++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL alu_en_unexpected: pc_o %0d with empty scoreboard", pc_o);
                end else begin
                    check("exec_pc", int'(pc_o), sb[0].pc);
                    check("exec_op", int'(alu_op), sb[0].op);
                    check("exec_imm", int'(alu_imm), sb[0].imm);
                end
            end
            if (rf_we) begin
                we_cnt++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rf_we_unexpected: pc_o %0d with empty scoreboard", pc_o);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("wb_pc", int'(pc_o), e.pc);
                    check("wb_sel", int'(rf_sel), e.sel);
                    check("wb_op", int'(alu_op), e.op);
                    check("wb_imm", int'(alu_imm), e.imm);
                end
            end
        end
    end

    task automatic run_prog(input string tag, input int exp_busy, input int exp_str,
                            input int exp_pc, input int exp_r1, input int exp_r3,
                            input int stop_at, input bit restart_mid);
        int b0, a0, w0, r10, r30;
        b0  = busy_cnt;
        a0  = alu_cnt;
        w0  = we_cnt;
        r10 = req1_cnt;
        r30 = req3_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_start_req"}, int'(imem_req), 1);
        check({tag, "_start_addr"}, int'(imem_addr), 0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            start = (restart_mid && i == 5) ? 1'b1 : 1'b0;
            stop  = (stop_at >= 0 && alu_en && int'(pc_o) == stop_at) ? 1'b1 : 1'b0;
            if (halted) break;
        end
        start = 1'b0;
        stop  = 1'b0;
        check({tag, "_halted"}, int'(halted), 1);
        check({tag, "_pc_o"}, int'(pc_o), exp_pc);
        check({tag, "_busy_cycles"}, busy_cnt - b0, exp_busy);
        check({tag, "_alu_pulses"}, alu_cnt - a0, exp_str);
        check({tag, "_we_pulses"}, we_cnt - w0, exp_str);
        check({tag, "_addr1_req_cycles"}, req1_cnt - r10, exp_r1);
        check({tag, "_addr3_req_cycles"}, req3_cnt - r30, exp_r3);
        check({tag, "_sb_drained"}, sb.size(), 0);
    endtask

    initial begin
        bit seen;
        prog[0] = 4'b1011;
        prog[1] = 4'b0110;
        prog[2] = 4'b0001;
        prog[3] = 4'b1100;
        for (int i = 4; i < 16; i++) prog[i] = 4'hF;
        for (int i = 0; i < 16; i++) wait_cfg[i] = 0;
        junk_on = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        rst_n   = 1'b1;

        // Reset state, applied asynchronously between clock edges.
        #3 rst_n = 1'b0;
        #1 check("reset_outputs", outs_vec(), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outputs", outs_vec(), 0);

        // Full zero-wait run.
        push_prog(4);
        run_prog("full", 16, 4, 0, 1, 1, -1, 1'b0);

        // Ack held off three cycles on pc=1; restart from HALT.
        wait_cfg[1] = 3;
        push_prog(4);
        run_prog("ackwait", 19, 4, 0, 4, 1, -1, 1'b0);
        wait_cfg[1] = 0;

        // Stop during EXEC of pc=2.
        push_prog(3);
        run_prog("stop", 12, 3, 3, 1, 0, 2, 1'b0);

        // Start while busy is ignored; restart from HALT begins at address 0.
        push_prog(4);
        run_prog("restart", 16, 4, 0, 1, 1, -1, 1'b1);

        // Junk acks in every non-FETCH cycle must never be latched.
        junk_on = 1'b1;
        push_prog(4);
        run_prog("junk", 16, 4, 0, 1, 1, -1, 1'b0);
        junk_on = 1'b0;

        // Reset while FETCH is stalled.
        wait_cfg[0] = 50;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rstfetch_req_before", int'(imem_req), 1);
        rst_n = 1'b0;
        #1 check("rstfetch_outputs", outs_vec(), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cfg[0] = 0;
        junk_on = 1'b1;
        repeat (4) @(negedge clk);
        check("rstfetch_stray_ack", outs_vec(), 0);
        junk_on = 1'b0;

        // Reset while EXEC strobe is high.
        push_prog(1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (alu_en) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rstexec_reached", int'(seen), 1);
        rst_n = 1'b0;
        #1 check("rstexec_outputs", outs_vec(), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rstexec_idle", outs_vec(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
